// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Purpose  : Shared packet-ID definitions and helpers for bus endpoints.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int              ID_W         = 8;
    localparam logic [ID_W-1:0] BCAST_ID_DEF = 8'hFF;
    localparam int              PKT_MAX_W    = 256;

    typedef enum logic [0:0] {
        PKT_MATCH    = 1'b0,
        PKT_MISROUTE = 1'b1
    } pkt_class_e;

    // The packet is passed zero-extended so one helper serves any packet width.
    function automatic logic [ID_W-1:0] get_id(input logic [PKT_MAX_W-1:0] pkt,
                                               input int unsigned          pkt_w);
        logic [PKT_MAX_W-1:0] w_sh;
        w_sh = pkt >> (pkt_w - ID_W);
        return w_sh[ID_W-1:0];
    endfunction

    function automatic pkt_class_e classify(input logic [ID_W-1:0] id,
                                            input logic [ID_W-1:0] my_id,
                                            input logic [ID_W-1:0] bcast_id);
        return ((id == my_id) || (id == bcast_id)) ? PKT_MATCH : PKT_MISROUTE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo
// Purpose  : Synchronous first-word fall-through FIFO with occupancy level.
// Revision : 1.0 - initial release
// ============================================================================
module rx_fifo #(
    parameter  int DW    = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_level
);

    localparam logic [AW:0] c_full_lvl = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_last;
    logic          w_rd;
    logic          w_wr;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_full  = (o_level == c_full_lvl);
    assign w_rd    = i_rd_en && !o_empty;
    assign w_wr    = i_wr_en && (!o_full || w_rd);

    // While empty, present the most recently popped word so dout stays stable.
    assign o_rd_data = o_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_rx_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : bus_rx_endpoint
// Purpose  : Bus sink port - ID filter, receive FIFO, valid/ready output, stats.
// Revision : 1.0 - initial release
// ============================================================================
module bus_rx_endpoint
    import bus_pkg::*;
#(
    parameter  int              pckg_sz   = 16,
    parameter  int              deep_fifo = 8,
    parameter  logic [ID_W-1:0] MY_ID     = 8'h00,
    parameter  logic [ID_W-1:0] BCAST_ID  = BCAST_ID_DEF,
    parameter  int              CNT_W     = 16,
    localparam int              LVL_W     = $clog2(deep_fifo) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic [pckg_sz-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    input  logic               clr_stats,
    output logic [LVL_W-1:0]   level,
    output logic               full,
    output logic               overflow,
    output logic [CNT_W-1:0]   rx_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic [CNT_W-1:0]   misroute_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    pkt_class_e w_class;
    logic       w_match;
    logic       w_misroute;
    logic       w_pop;
    logic       w_wr_en;
    logic       w_drop;
    logic       w_empty;

    assign w_class    = classify(get_id(PKT_MAX_W'(D_push), pckg_sz), MY_ID, BCAST_ID);
    assign w_match    = push && (w_class == PKT_MATCH);
    assign w_misroute = push && (w_class == PKT_MISROUTE);
    assign w_pop      = dout_valid && dout_ready;
    // A pop at the same edge frees the slot, so a full FIFO still accepts.
    assign w_wr_en    = w_match && (!full || w_pop);
    assign w_drop     = w_match && full && !w_pop;
    assign dout_valid = !w_empty;

    rx_fifo #(
        .DW    (pckg_sz),
        .DEPTH (deep_fifo)
    ) u_fifo (
        .clk       (clk),
        .i_rst_n   (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_data (D_push),
        .i_rd_en   (w_pop),
        .o_rd_data (dout),
        .o_empty   (w_empty),
        .o_full    (full),
        .o_level   (level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_count       <= '0;
            drop_count     <= '0;
            misroute_count <= '0;
            overflow       <= 1'b0;
        end else if (clr_stats) begin
            rx_count       <= '0;
            drop_count     <= '0;
            misroute_count <= '0;
            overflow       <= 1'b0;
        end else begin
            if (w_wr_en && (rx_count != c_cnt_max)) begin
                rx_count <= rx_count + 1'b1;
            end
            if (w_drop && (drop_count != c_cnt_max)) begin
                drop_count <= drop_count + 1'b1;
            end
            if (w_misroute && (misroute_count != c_cnt_max)) begin
                misroute_count <= misroute_count + 1'b1;
            end
            if (w_drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_rx_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_rx_endpoint
// Purpose  : Self-checking bench for bus_rx_endpoint against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_rx_endpoint;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        push       = 1'b0;
    logic [15:0] D_push     = '0;
    logic        dout_ready = 1'b0;
    logic        clr_stats  = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic [3:0]  level;
    logic        full;
    logic        overflow;
    logic [15:0] rx_count;
    logic [15:0] drop_count;
    logic [15:0] misroute_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mq[$];
    int          m_rx, m_drop, m_mis;
    bit          m_ovf;

    bus_rx_endpoint #(
        .pckg_sz   (16),
        .deep_fifo (8),
        .MY_ID     (8'h02),
        .BCAST_ID  (8'hFF),
        .CNT_W     (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .push           (push),
        .D_push         (D_push),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .clr_stats      (clr_stats),
        .level          (level),
        .full           (full),
        .overflow       (overflow),
        .rx_count       (rx_count),
        .drop_count     (drop_count),
        .misroute_count (misroute_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_rx   = 0;
        m_drop = 0;
        m_mis  = 0;
        m_ovf  = 1'b0;
    endtask

    function automatic logic [6:0] exp_status();
        return {mq.size() > 0, 4'(mq.size()), mq.size() == 8, m_ovf};
    endfunction

    function automatic logic [47:0] exp_counts();
        return {16'(m_rx), 16'(m_drop), 16'(m_mis)};
    endfunction

    // Drive one cycle, advance the model by the receive rules, sample 1ns after the edge.
    task automatic cycle(input bit p, input logic [15:0] d, input bit r, input bit c);
        bit match;
        bit was_full;
        bit pop;
        push       = p;
        D_push     = p ? d : 'x;
        dout_ready = r;
        clr_stats  = c;
        @(posedge clk);
        match    = p && (d[15:8] == 8'h02 || d[15:8] == 8'hFF);
        was_full = (mq.size() == 8);
        pop      = r && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (match) begin
            if (!was_full || pop) begin
                mq.push_back(d);
                if (m_rx < 65535) m_rx++;
            end else begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1'b1;
            end
        end
        if (p && !match && m_mis < 65535) m_mis++;
        if (c) begin
            m_rx = 0; m_drop = 0; m_mis = 0; m_ovf = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({dout_valid, level, full, overflow, dout} !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_status got v=%b lvl=%0d f=%b o=%b dout=%h exp all 0",
                     dout_valid, level, full, overflow, dout);
        end
        n_checks++;
        if ({rx_count, drop_count, misroute_count} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_counts got %h/%h/%h exp 0", rx_count, drop_count, misroute_count);
        end
        reset = 1'b1;
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        n_checks++;
        if ({dout_valid, level, full, overflow} !== 7'h0) begin
            n_fail++;
            $display("FAIL reset_release got %b exp 0", {dout_valid, level, full, overflow});
        end
    endtask

    task automatic test_single();
        cycle(1'b1, 16'h0203, 1'b1, 1'b0);
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== 16'h0203) begin
            n_fail++;
            $display("FAIL single_out got v=%b dout=%h exp v=1 dout=0203", dout_valid, dout);
        end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        n_checks++;
        if (rx_count !== 16'd1 || level !== 4'd0 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop got rx=%0d lvl=%0d v=%b exp rx=1 lvl=0 v=0",
                     rx_count, level, dout_valid);
        end
    endtask

    task automatic test_misroute();
        cycle(1'b1, 16'hFF07, 1'b0, 1'b0);
        cycle(1'b1, 16'h0307, 1'b0, 1'b0);
        n_checks++;
        if (misroute_count !== 16'd1 || level !== 4'd1 || dout !== 16'hFF07) begin
            n_fail++;
            $display("FAIL misroute got mis=%0d lvl=%0d dout=%h exp mis=1 lvl=1 dout=ff07",
                     misroute_count, level, dout);
        end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        n_checks++;
        if (dout_valid !== 1'b0 || level !== 4'd0) begin
            n_fail++;
            $display("FAIL misroute_drain got v=%b lvl=%0d exp v=0 lvl=0", dout_valid, level);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) cycle(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
        n_checks++;
        if (level !== 4'd8 || full !== 1'b1 || drop_count !== 16'd1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_fill got lvl=%0d f=%b drop=%0d o=%b exp 8/1/1/1",
                     level, full, drop_count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (dout_valid !== 1'b1 || dout !== 16'(16'h0200 + i)) begin
                n_fail++;
                $display("FAIL overflow_drain[%0d] got v=%b dout=%h exp v=1 dout=%h",
                         i, dout_valid, dout, 16'(16'h0200 + i));
            end
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        end
        n_checks++;
        if ({dout_valid, level, full, overflow} !== exp_status()) begin
            n_fail++;
            $display("FAIL overflow_empty got %b exp %b", {dout_valid, level, full, overflow}, exp_status());
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp_seq [8];
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'h0209, 1'b1, 1'b0);
        n_checks++;
        if (level !== 4'd8 || full !== 1'b1 || drop_count !== 16'd1) begin
            n_fail++;
            $display("FAIL fullpp got lvl=%0d f=%b drop=%0d exp lvl=8 f=1 drop=1",
                     level, full, drop_count);
        end
        for (int i = 0; i < 7; i++) exp_seq[i] = 16'(16'h0201 + i);
        exp_seq[7] = 16'h0209;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (dout_valid !== 1'b1 || dout !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL fullpp_drain[%0d] got v=%b dout=%h exp v=1 dout=%h",
                         i, dout_valid, dout, exp_seq[i]);
            end
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h0210 + i), 1'b0, 1'b0);
        push   = 1'b1;
        D_push = 16'h0204;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (dout_valid !== 1'b0 || level !== 4'd0 || full !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b lvl=%0d f=%b o=%b exp all 0",
                     dout_valid, level, full, overflow);
        end
        n_checks++;
        if ({rx_count, drop_count, misroute_count} !== 48'h0) begin
            n_fail++;
            $display("FAIL async_reset_cnt got %h/%h/%h exp 0", rx_count, drop_count, misroute_count);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        push  = 1'b0;
        cycle(1'b1, 16'h0201, 1'b0, 1'b1);
        n_checks++;
        if ({rx_count, drop_count, misroute_count} !== 48'h0 || level !== 4'd1
            || dout_valid !== 1'b1 || dout !== 16'h0201) begin
            n_fail++;
            $display("FAIL clr_with_push got rx=%0d lvl=%0d v=%b dout=%h exp rx=0 lvl=1 v=1 dout=0201",
                     rx_count, level, dout_valid, dout);
        end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0]  id;
        logic [15:0] d;
        bit          p, r, c;
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0, 3:    id = 8'h02;
                1:       id = 8'hFF;
                default: id = 8'($urandom);
            endcase
            d = {id, 8'($urandom)};
            // Alternate slow and fast consumer phases to reach full and empty often.
            r = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 59) == 0);
            cycle(p, d, r, c);
            n_checks++;
            if ({dout_valid, level, full, overflow} !== exp_status()) begin
                n_fail++;
                $display("FAIL rand_status[%0d] got %b exp %b", i,
                         {dout_valid, level, full, overflow}, exp_status());
            end
            n_checks++;
            if ({rx_count, drop_count, misroute_count} !== exp_counts()) begin
                n_fail++;
                $display("FAIL rand_counts[%0d] got %h exp %h", i,
                         {rx_count, drop_count, misroute_count}, exp_counts());
            end
            if (mq.size() > 0) begin
                n_checks++;
                if (dout !== mq[0]) begin
                    n_fail++;
                    $display("FAIL rand_dout[%0d] got %h exp %h", i, dout, mq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_misroute();
        test_overflow();
        test_full_push_pop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
